// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio types, limits and default filter geometry
package audio_pkg;

  typedef logic signed [15:0] pcm_t;

  localparam pcm_t PCM_MAX = 16'sh7fff;
  localparam pcm_t PCM_MIN = 16'sh8000;

  localparam int DEFAULT_R       = 64;
  localparam int DEFAULT_N       = 4;
  localparam int DEFAULT_CLK_DIV = 12;

  // Clamp a 17-bit scaled filter value into the Q15 range; an overflow shows
  // up as disagreeing top two bits, and the sign bit picks the rail.
  function automatic pcm_t sat_pcm(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      return v[16] ? PCM_MIN : PCM_MAX;
    end
    return v[15:0];
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// rtl/pdm_clk_gen.sv - PDM mic clock divider, data synchroniser and bit strobe
module pdm_clk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic pdm_data,
  output logic pdm_clk,
  output logic bit_en,
  output logic bit_data
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       sync;

  // Half-period divider; disabling parks the mic clock low so a restart
  // always begins with a full low phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      pdm_clk <= ~pdm_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Two-flop synchroniser for the asynchronous mic data line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], pdm_data};
    end
  end

  // Take the bit at the very end of the high phase, when the mic output has
  // had the longest time to settle through the synchroniser.
  assign bit_en   = enable && pdm_clk && (div_cnt == DIV_LAST);
  assign bit_data = sync[1];

endmodule

// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - PDM front end with N-stage CIC decimation to Q15 PCM
module pdm_cic_decimator
  import audio_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int R       = DEFAULT_R,
  parameter int N       = DEFAULT_N,
  parameter int ACC_W   = 2 + N * $clog2(R)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic pdm_data,
  output logic pdm_clk,
  output pcm_t sample_out,
  output logic sample_valid
);

  localparam int DEC_W  = $clog2(R);
  localparam int SHIFT  = ACC_W - 17;
  localparam int WARM_W = $clog2(N + 1);

  typedef logic signed [ACC_W-1:0] acc_t;

  logic              bit_en;
  logic              bit_data;
  logic [DEC_W-1:0]  dec_cnt;
  logic              dec_event;
  logic [N-1:0]      stage_vld;
  logic [WARM_W-1:0] warm_cnt;
  acc_t              bit_val;
  acc_t              comb_out;
  logic signed [16:0] scaled;
  logic              unused_lsbs;

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .pdm_data (pdm_data),
    .pdm_clk  (pdm_clk),
    .bit_en   (bit_en),
    .bit_data (bit_data)
  );

  assign bit_val   = bit_data ? acc_t'(1) : acc_t'(-1);
  assign dec_event = bit_en && (&dec_cnt);

  // Decimation phase counter; R is a power of two so it wraps on its own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_cnt <= '0;
    end else if (!enable) begin
      dec_cnt <= '0;
    end else if (bit_en) begin
      dec_cnt <= dec_cnt + 1'b1;
    end
  end

  // Integrator cascade: each stage adds the freshly updated value of the one
  // before it, so all stages settle within the bit_en cycle. Wrap is relied on.
  for (genvar k = 0; k < N; k++) begin : g_int
    acc_t acc_q;
    acc_t sum;
    if (k == 0) begin : g_first
      assign sum = acc_q + bit_val;
    end else begin : g_rest
      assign sum = acc_q + g_int[k-1].sum;
    end

    // Integrator state, advanced once per PDM bit.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_q <= '0;
      end else if (!enable) begin
        acc_q <= '0;
      end else if (bit_en) begin
        acc_q <= sum;
      end
    end
  end

  // Comb pipeline; stage 0 consumes the integrator result on the decimation
  // cycle, each later stage moves one cycle behind its predecessor.
  for (genvar k = 0; k < N; k++) begin : g_comb
    acc_t c_q;
    acc_t d_q;
    acc_t cin;
    logic adv;
    if (k == 0) begin : g_first
      assign cin = g_int[N-1].sum;
      assign adv = dec_event;
    end else begin : g_rest
      assign cin = g_comb[k-1].c_q;
      assign adv = stage_vld[k-1];
    end

    // Differentiator with its own one-sample delay.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        c_q <= '0;
        d_q <= '0;
      end else if (!enable) begin
        c_q <= '0;
        d_q <= '0;
      end else if (adv) begin
        c_q <= cin - d_q;
        d_q <= cin;
      end
    end
  end

  // Valid tokens that walk alongside the comb stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_vld <= '0;
    end else if (!enable) begin
      stage_vld <= '0;
    end else begin
      stage_vld <= {stage_vld[N-2:0], dec_event};
    end
  end

  assign comb_out    = g_comb[N-1].c_q;
  assign scaled      = comb_out[ACC_W-1:SHIFT];
  assign unused_lsbs = ^comb_out[SHIFT-1:0];

  // Output register; the first N results only prime the comb delays, so
  // they update sample_out but never raise the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      warm_cnt     <= '0;
    end else if (!enable) begin
      sample_valid <= 1'b0;
      warm_cnt     <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (stage_vld[N-1]) begin
        sample_out <= sat_pcm(scaled);
        if (warm_cnt == WARM_W'(N)) begin
          sample_valid <= 1'b1;
        end else begin
          warm_cnt <= warm_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb/tb_pdm_cic_decimator.sv - self-checking bench for pdm_cic_decimator
module tb_pdm_cic_decimator;

  localparam int CLK_DIV = 12;
  localparam int R       = 64;
  localparam int N       = 4;
  localparam int FRAME   = 2 * CLK_DIV * R;
  localparam int L       = N * (R - 1) + 1;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic               pdm_data = 1'b0;
  logic               pdm_clk;
  logic signed [15:0] sample_out;
  logic               sample_valid;

  pdm_cic_decimator #(
    .CLK_DIV (CLK_DIV),
    .R       (R),
    .N       (N)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .pdm_data     (pdm_data),
    .pdm_clk      (pdm_clk),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc = 0;
  int strobes = 0;
  int mode = 1;
  int density = 50;
  int bits[$];
  longint h[L];

  always @(posedge clk) cyc <= cyc + 1;

  // Mic model: present a new bit shortly after each rising mic clock edge.
  always @(posedge pdm_clk) begin
    int b;
    #1;
    case (mode)
      0:       b = ($urandom_range(0, 99) < density) ? 1 : 0;
      1:       b = 1;
      2:       b = 0;
      3:       b = (bits.size() % 2 == 0) ? 1 : 0;
      default: b = (bits.size() % 4 != 3) ? 1 : 0;
    endcase
    pdm_data = b[0];
    bits.push_back(b == 1 ? 1 : -1);
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Impulse response of N cascaded length-R boxcars.
  task automatic build_h();
    longint tmp[L];
    for (int i = 0; i < L; i++) h[i] = (i < R) ? 1 : 0;
    for (int s = 1; s < N; s++) begin
      for (int i = 0; i < L; i++) begin
        tmp[i] = 0;
        for (int k = 0; k < R; k++) if (i - k >= 0) tmp[i] += h[i-k];
      end
      h = tmp;
    end
  endtask

  // Expected PCM for decimation event e (1-based) since the last restart.
  function automatic longint model_pcm(input int e);
    longint y = 0;
    longint s;
    int n = e * R - 1;
    for (int j = 0; j < L; j++)
      if (n - j >= 0 && n - j < bits.size()) y += h[j] * bits[n-j];
    s = y >>> 9;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic wait_strobe(input int budget, output bit got);
    int w = 0;
    got = 1'b0;
    while (w < budget && !got) begin
      @(negedge clk);
      w++;
      if (sample_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic take(input string tag, input int budget, input bit chk_const,
                      input int cval, input bit chk_period);
    bit got;
    wait_strobe(budget, got);
    check({tag, "_strobe_seen"}, got, 1);
    if (got) begin
      strobes++;
      check({tag, "_model"}, sample_out, model_pcm(strobes + N));
      if (chk_const) check({tag, "_level"}, sample_out, cval);
      if (chk_period) check({tag, "_period"}, cyc - last_cyc, FRAME);
      last_cyc = cyc;
      @(negedge clk);
      check({tag, "_single_cycle"}, sample_valid, 0);
    end
  endtask

  task automatic quiet_warmup(input string tag);
    bit got;
    wait_strobe((N + 1) * FRAME - 200, got);
    check({tag, "_warmup_quiet"}, got, 0);
  endtask

  initial begin
    int highs;
    logic signed [15:0] held;
    build_h();

    // Reset state
    mode = 1;
    repeat (3) @(negedge clk);
    check("rst_pdm_clk", pdm_clk, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_sample_valid", sample_valid, 0);

    // Constant ones from reset: warm-up, then positive full scale clamps
    bits.delete();
    strobes = 0;
    reset_n = 1'b1;
    enable = 1'b1;
    quiet_warmup("ones");
    take("ones_first", 400, 1, 32767, 0);
    take("ones", FRAME + 50, 1, 32767, 1);
    take("ones", FRAME + 50, 1, 32767, 1);

    // Drop enable mid-frame for 100 cycles
    repeat (700) @(negedge clk);
    held = sample_out;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("dis_pdm_clk_low", pdm_clk, 0);
    highs = 0;
    repeat (99) begin
      @(negedge clk);
      if (sample_valid !== 1'b0) highs++;
    end
    check("dis_no_strobe", highs, 0);
    check("dis_sample_held", sample_out, held);
    bits.delete();
    strobes = 0;
    enable = 1'b1;
    quiet_warmup("restart");
    take("restart_first", 400, 1, 32767, 0);
    take("restart", FRAME + 50, 1, 32767, 1);

    // One-cycle reset mid-frame, then constant zeros
    repeat (500) @(negedge clk);
    mode = 2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pdm_clk", pdm_clk, 0);
    check("async_rst_sample_out", sample_out, 0);
    check("async_rst_sample_valid", sample_valid, 0);
    @(negedge clk);
    bits.delete();
    strobes = 0;
    reset_n = 1'b1;
    quiet_warmup("zeros");
    take("zeros_first", 400, 1, -32768, 0);
    take("zeros", FRAME + 50, 1, -32768, 1);
    take("zeros", FRAME + 50, 1, -32768, 1);

    // Alternating bits: transients against the model, then midscale
    mode = 3;
    repeat (5) take("toggle_settle", FRAME + 50, 0, 0, 1);
    take("toggle", FRAME + 50, 1, 0, 1);

    // 75 percent ones
    mode = 4;
    repeat (5) take("dens75_settle", FRAME + 50, 0, 0, 1);
    take("dens75", FRAME + 50, 1, 16384, 1);

    // Random streams of two densities
    density = 50;
    mode = 0;
    repeat (3) take("rand50", FRAME + 50, 0, 0, 1);
    density = 85;
    repeat (3) take("rand85", FRAME + 50, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
